updown_mod_counter: RTL and testbench
=====================================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 The block SHALL have parameter MAX, default 2**WIDTH-1, the terminal count; the count range is 0..MAX (legal 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0; 0 means wrap mode, 1 means saturate mode.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous clear of count.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 en  input  1  count enable.
REQ-010 up  input  1  direction; 1 is increment, 0 is decrement.
REQ-011 ovf_clr  input  1  clear for the sticky overflow flag.
REQ-012 count  output  WIDTH  registered count value.
REQ-013 tc  output  1  registered one-cycle pulse marking a boundary event.
REQ-014 ovf  output  1  registered sticky boundary-event flag.
REQ-015 at_max  output  1  combinational; high when count==MAX.
REQ-016 at_min  output  1  combinational; high when count==0.

Function
REQ-017 Per-edge priority SHALL be clr > load > en; when none is asserted, count SHALL hold.
REQ-018 clr SHALL set count to 0 on the next edge, with no tc pulse and no change to ovf.
REQ-019 load SHALL set count to load_val; a load_val greater than MAX SHALL be clamped to MAX; load SHALL NOT produce a tc pulse.
REQ-020 With en=1 and up=1 and count<MAX, count SHALL increment by 1.
REQ-021 With en=1 and down (up=0) and count>0, count SHALL decrement by 1.
REQ-022 With en=1, up=1 and count==MAX, a boundary event SHALL occur: count goes to 0 when SATURATE=0, or holds MAX when SATURATE=1.
REQ-023 With en=1, up=0 and count==0, a boundary event SHALL occur: count goes to MAX when SATURATE=0, or holds 0 when SATURATE=1.
REQ-024 tc SHALL be 1 for exactly the cycle after the edge on which a boundary event occurs, and 0 otherwise; back-to-back events (e.g. saturate held with en=1) SHALL keep tc high on every such cycle.
REQ-025 ovf SHALL be set on any boundary event and SHALL stay set until ovf_clr is sampled high.
REQ-026 If ovf_clr is high on the same edge as a boundary event, ovf SHALL remain 1 (set wins).
REQ-027 Latency from any control input to count, tc or ovf SHALL be one clock edge.
REQ-028 at_max and at_min SHALL reflect the current registered count with zero latency.
REQ-029 Arithmetic SHALL be unsigned modulo MAX+1; count SHALL never exceed MAX in any mode.

Reset
REQ-030 While rst=1, count SHALL be 0, tc SHALL be 0, and ovf SHALL be 0, immediately and independent of clk.
REQ-031 Assertion of rst mid-count SHALL abort any pending update.
REQ-032 The first edge after rst deasserts SHALL obey REQ-017..REQ-026.

Verification
REQ-033 WIDTH=4, MAX=9, SATURATE=0, en=1, up=1 from reset, 10 edges -> count 1..9 then 0; tc=1 only in the cycle count returns to 0; ovf=1 thereafter.
REQ-034 Same configuration, up=0 from count=0, 1 edge -> count=9, tc=1, at_max=1.
REQ-035 SATURATE=1, MAX=9, load_val=12 with load=1 -> count=9; then en=1, up=1 for 3 edges -> count stays 9, tc=1 for 3 cycles.
REQ-036 clr=1, load=1, en=1 on the same edge with count=5 -> count=0 and tc=0; then load=1 alone with load_val=7 -> count=7.
REQ-037 ovf=1, then ovf_clr=1 on the same edge as a wrap event -> ovf stays 1; ovf_clr=1 on the next edge with no event -> ovf=0.
REQ-038 rst asserted between edges while count=6 -> count, tc and ovf read 0 before the next edge; after release with en=1, up=1 -> count=1 on the first edge.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo-(MAX+1) counter with synchronous clear/load, wrap or saturate
// at the boundaries, a one-cycle terminal-count pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic             ovf_r;
  logic [WIDTH-1:0] count_nxt_s;
  logic             event_s;
  logic             ovf_nxt_s;

  function automatic logic [WIDTH-1:0] clamp_max(input logic [WIDTH-1:0] v);
    if (v > MAX) begin
      clamp_max = MAX;
    end else begin
      clamp_max = v;
    end
  endfunction

  // Next-count selection: clr beats load beats en; boundary steps flag an event.
  always_comb begin
    count_nxt_s = count_r;
    event_s     = 1'b0;
    if (clr) begin
      count_nxt_s = ZERO;
    end else if (load) begin
      count_nxt_s = clamp_max(load_val);
    end else if (en) begin
      if (up) begin
        if (count_r >= MAX) begin
          event_s     = 1'b1;
          count_nxt_s = SATURATE ? MAX : ZERO;
        end else begin
          count_nxt_s = count_r + ONE;
        end
      end else begin
        if (count_r == ZERO) begin
          event_s     = 1'b1;
          count_nxt_s = SATURATE ? ZERO : MAX;
        end else begin
          count_nxt_s = count_r - ONE;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
    // A boundary event on the same edge as ovf_clr keeps the flag set.
    ovf_nxt_s = event_s | (ovf_r & ~ovf_clr);
  end

  // State registers; rst clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= ZERO;
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= event_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign count  = count_r;
  assign tc     = tc_r;
  assign ovf    = ovf_r;
  assign at_max = (count_r == MAX);
  assign at_min = (count_r == ZERO);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter (WIDTH=4, MAX=9)
// driven with directed vectors; a monitor pops expected results each cycle.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr0 = 1'b0, load0 = 1'b0, en0 = 1'b0, up0 = 1'b0, oc0 = 1'b0;
  logic       clr1 = 1'b0, load1 = 1'b0, en1 = 1'b0, up1 = 1'b0, oc1 = 1'b0;
  logic [3:0] lv0 = 4'd0, lv1 = 4'd0;
  logic [3:0] cnt0, cnt1;
  logic       tc0, tc1, ovf0, ovf1, amax0, amax1, amin0, amin1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         d;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    logic       amax;
    logic       amin;
    string      nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr0), .load(load0), .load_val(lv0), .en(en0),
    .up(up0), .ovf_clr(oc0), .count(cnt0), .tc(tc0), .ovf(ovf0),
    .at_max(amax0), .at_min(amin0)
  );

  updown_mod_counter #(.WIDTH(4), .MAX(4'd9), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .load(load1), .load_val(lv1), .en(en1),
    .up(up1), .ovf_clr(oc1), .count(cnt1), .tc(tc1), .ovf(ovf1),
    .at_max(amax1), .at_min(amin1)
  );

  task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on DUT d and queue the expected post-edge state.
  task automatic step(input int d, input logic c, input logic l, input logic [3:0] lv,
                      input logic e, input logic u, input logic oc,
                      input logic [3:0] ec, input logic et, input logic eo, input string nm);
    exp_t x;
    @(negedge clk);
    if (d == 0) begin
      clr0 = c; load0 = l; lv0 = lv; en0 = e; up0 = u; oc0 = oc;
    end else begin
      clr1 = c; load1 = l; lv1 = lv; en1 = e; up1 = u; oc1 = oc;
    end
    x.d = d; x.cnt = ec; x.tc = et; x.ovf = eo;
    x.amax = (ec == 4'd9); x.amin = (ec == 4'd0); x.nm = nm;
    q.push_back(x);
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        x = q.pop_front();
        if (x.d == 0) begin
          chk(x.nm, "count", cnt0, x.cnt);
          chk(x.nm, "tc", {3'd0, tc0}, {3'd0, x.tc});
          chk(x.nm, "ovf", {3'd0, ovf0}, {3'd0, x.ovf});
          chk(x.nm, "at_max", {3'd0, amax0}, {3'd0, x.amax});
          chk(x.nm, "at_min", {3'd0, amin0}, {3'd0, x.amin});
        end else begin
          chk(x.nm, "count", cnt1, x.cnt);
          chk(x.nm, "tc", {3'd0, tc1}, {3'd0, x.tc});
          chk(x.nm, "ovf", {3'd0, ovf1}, {3'd0, x.ovf});
          chk(x.nm, "at_max", {3'd0, amax1}, {3'd0, x.amax});
          chk(x.nm, "at_min", {3'd0, amin1}, {3'd0, x.amin});
        end
      end
    end
  end

  initial begin
    #1;
    chk("reset", "count", cnt0, 4'd0);
    chk("reset", "tc", {3'd0, tc0}, 4'd0);
    chk("reset", "ovf", {3'd0, ovf0}, 4'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Wrap-mode counter.
    step(0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "idle_after_rst");
    for (int i = 1; i <= 9; i++)
      step(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'(i), 1'b0, 1'b0, "inc");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, "wrap_up");
    step(0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "hold");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1, "wrap_down");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, "dec");
    step(0, 1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, "load9");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, "ovf_set_wins");
    step(0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "ovf_clr");
    step(0, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, "load5");
    step(0, 1'b1, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "clr_prio");
    step(0, 1'b0, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, "load7");
    step(0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, "load_clamp");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, "wrap_again");
    step(0, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "clr_keeps_ovf");
    step(0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, "load_over_en");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, "inc_ovf_clr");
    step(0, 1'b0, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, "load9b");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, "wrap_b");
    step(0, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, "load5b");
    step(0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, "inc_to6");

    // Asynchronous reset between edges while counting.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_async", "count", cnt0, 4'd0);
    chk("rst_async", "tc", {3'd0, tc0}, 4'd0);
    chk("rst_async", "ovf", {3'd0, ovf0}, 4'd0);
    @(posedge clk);
    #1;
    chk("rst_held", "count", cnt0, 4'd0);
    #2 rst = 1'b0;
    step(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, "first_after_rst");
    @(negedge clk);
    en0 = 1'b0; up0 = 1'b0;

    // Saturate-mode counter.
    step(1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "sat_idle");
    step(1, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, "sat_load_clamp");
    for (int i = 0; i < 3; i++)
      step(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd9, 1'b1, 1'b1, "sat_hold_max");
    step(1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b1, "sat_idle_max");
    step(1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, "sat_dec");
    step(1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "sat_load0");
    step(1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, "sat_hold_min");
    step(1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, "sat_set_wins");
    step(1, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, "sat_ovf_clr");
    step(1, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, "sat_inc");
    @(negedge clk);
    en1 = 1'b0;

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
